bp_fe_btb_tagged: RTL and testbench

BP_FE_BTB_TAGGED -- requirements
Module: bp_fe_btb_tagged

---
 rtl/bp_fe_pkg.sv | 27 ++
 rtl/bsg_mem_1r1w_sync.sv | 47 ++++
 rtl/bp_fe_btb_tagged.sv | 238 +++++++++++++++++++++++
 tb/tb_bp_fe_btb_tagged.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end branch target buffer.
// Holds the tag/valid entry struct, the BTB state enum and a tag-match helper.
package bp_fe_pkg;

    // Upper bound on the stored tag width.
    // Narrower tags are zero-extended into this field.
    localparam int bp_fe_btb_tag_width_max_gp = 32;

    typedef logic [bp_fe_btb_tag_width_max_gp-1:0] bp_fe_btb_tag_t;

    typedef struct packed {
        logic           v;
        bp_fe_btb_tag_t tag;
    } bp_fe_btb_tag_entry_s;

    typedef enum logic [0:0] {
        e_btb_init  = 1'b0,
        e_btb_ready = 1'b1
    } bp_fe_btb_state_e;

    // A way matches only when it is valid and its stored tag equals the probe tag.
    function automatic logic bp_fe_btb_tag_match(input bp_fe_btb_tag_entry_s entry,
                                                 input bp_fe_btb_tag_t tag);
        return entry.v && (entry.tag == tag);
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync.sv
// One-read one-write synchronous RAM with a per-lane (per-way) write mask.
// A read and a write to the same row in one cycle return the old row contents.
module bsg_mem_1r1w_sync #(
    parameter int width_p      = 78,
    parameter int els_p        = 64,
    parameter int addr_width_p = 6,
    parameter int ways_p       = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_v_i,
    input  logic [ways_p-1:0]       w_mask_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic                    r_v_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    localparam int lane_lp = width_p / ways_p;

    logic [width_p-1:0] mem_r [els_p];
    logic [width_p-1:0] r_data_r;

    // Array write: only the lanes selected by the mask are updated.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            for (int w = 0; w < ways_p; w++) begin
                if (w_mask_i[w]) begin
                    mem_r[w_addr_i][w*lane_lp +: lane_lp] <= w_data_i[w*lane_lp +: lane_lp];
                end
            end
        end
    end

    // Registered read port; it holds its value when no read is requested.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data_r <= {width_p{1'b0}};
        end else if (r_v_i) begin
            r_data_r <= mem_r[r_addr_i];
        end
    end

    assign r_data_o = r_data_r;

endmodule

// File: rtl/bp_fe_btb_tagged.sv
// Set-associative tagged branch target buffer.
// Tags, valid bits and round-robin pointers live in flops; targets live in a sync RAM.
// After reset or flush, an INIT sweep clears one set per cycle.
// Optional build macro BP_FE_BTB_BYPASS_EN: a same-cycle write to the same set and tag
// as an accepted read is forwarded to that read's response.
module bp_fe_btb_tagged
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p   = 39,
    parameter int btb_idx_width_p = 6,
    parameter int btb_tag_width_p = 10,
    parameter int btb_ways_p      = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    output logic                     ready_o,
    input  logic                     r_v_i,
    input  logic [vaddr_width_p-1:0] r_addr_i,
    output logic                     r_v_o,
    output logic                     r_hit_o,
    output logic [vaddr_width_p-1:0] r_target_o,
    input  logic                     w_v_i,
    input  logic [vaddr_width_p-1:0] w_addr_i,
    input  logic [vaddr_width_p-1:0] w_target_i
);

    localparam int sets_lp    = 1 << btb_idx_width_p;
    localparam int way_w_lp   = (btb_ways_p > 1) ? $clog2(btb_ways_p) : 1;
    localparam int tag_lsb_lp = btb_idx_width_p + 2;
    localparam int tag_msb_lp = btb_tag_width_p + btb_idx_width_p + 1;

    bp_fe_btb_state_e             state_r, state_n;
    logic [btb_idx_width_p-1:0]   init_cnt_r, init_cnt_n;

    bp_fe_btb_tag_entry_s         tag_r [sets_lp][btb_ways_p];
    logic [way_w_lp-1:0]          ptr_r [sets_lp];

    logic [btb_idx_width_p-1:0]   r_idx_s, w_idx_s;
    bp_fe_btb_tag_t               r_tag_s, w_tag_s;
    logic                         r_acc_s, w_acc_s;

    logic                         r_hit_s;
    logic [way_w_lp-1:0]          r_way_s;
    logic                         w_hit_s, w_inv_s, w_adv_s;
    logic [way_w_lp-1:0]          w_hit_way_s, w_inv_way_s, w_way_s;
    logic [way_w_lp-1:0]          w_ptr_next_s;
    logic [btb_ways_p-1:0]        w_mask_s;
    logic                         byp_s;

    logic                         resp_v_r, resp_hit_r, resp_byp_r;
    logic [way_w_lp-1:0]          resp_way_r;
    logic [vaddr_width_p-1:0]     resp_byp_tgt_r;
    logic [btb_ways_p*vaddr_width_p-1:0] mem_data_s;

    // Only the index and tag slices of the addresses are meaningful.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{r_addr_i, w_addr_i};

    assign r_idx_s = r_addr_i[btb_idx_width_p+1:2];
    assign w_idx_s = w_addr_i[btb_idx_width_p+1:2];
    assign r_tag_s = bp_fe_btb_tag_t'(r_addr_i[tag_msb_lp:tag_lsb_lp]);
    assign w_tag_s = bp_fe_btb_tag_t'(w_addr_i[tag_msb_lp:tag_lsb_lp]);

    assign ready_o = (state_r == e_btb_ready);
    assign r_acc_s = r_v_i & ready_o & ~reset_i;
    // A flush wins over a write presented in the same cycle.
    assign w_acc_s = w_v_i & ready_o & ~reset_i & ~flush_i;

    // State register and INIT sweep counter; reset restarts the sweep at set 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_btb_init;
            init_cnt_r <= {btb_idx_width_p{1'b0}};
        end else begin
            state_r    <= state_n;
            init_cnt_r <= init_cnt_n;
        end
    end

    // Next-state logic: sweep every set once, then serve until a flush.
    always_comb begin
        state_n    = state_r;
        init_cnt_n = init_cnt_r;
        case (state_r)
            e_btb_init: begin
                if (flush_i) begin
                    init_cnt_n = {btb_idx_width_p{1'b0}};
                end else if (init_cnt_r == {btb_idx_width_p{1'b1}}) begin
                    state_n    = e_btb_ready;
                    init_cnt_n = {btb_idx_width_p{1'b0}};
                end else begin
                    init_cnt_n = init_cnt_r + {{(btb_idx_width_p-1){1'b0}}, 1'b1};
                end
            end
            e_btb_ready: begin
                if (flush_i) begin
                    state_n    = e_btb_init;
                    init_cnt_n = {btb_idx_width_p{1'b0}};
                end else begin
                    state_n    = e_btb_ready;
                end
            end
            default: begin
                state_n    = e_btb_init;
                init_cnt_n = {btb_idx_width_p{1'b0}};
            end
        endcase
    end

    // Read-side tag compare against the pre-write contents of the set.
    always_comb begin
        r_hit_s = 1'b0;
        r_way_s = {way_w_lp{1'b0}};
        for (int w = btb_ways_p - 1; w >= 0; w--) begin
            if (bp_fe_btb_tag_match(tag_r[r_idx_s][w], r_tag_s)) begin
                r_hit_s = 1'b1;
                r_way_s = way_w_lp'(w);
            end else begin
                r_hit_s = r_hit_s;
            end
        end
    end

    // Write-side way selection.
    // Priority: a hit way, then the lowest invalid way, then the round-robin victim.
    always_comb begin
        w_hit_s     = 1'b0;
        w_hit_way_s = {way_w_lp{1'b0}};
        w_inv_s     = 1'b0;
        w_inv_way_s = {way_w_lp{1'b0}};
        for (int w = btb_ways_p - 1; w >= 0; w--) begin
            if (bp_fe_btb_tag_match(tag_r[w_idx_s][w], w_tag_s)) begin
                w_hit_s     = 1'b1;
                w_hit_way_s = way_w_lp'(w);
            end else begin
                w_hit_s     = w_hit_s;
            end
            if (!tag_r[w_idx_s][w].v) begin
                w_inv_s     = 1'b1;
                w_inv_way_s = way_w_lp'(w);
            end else begin
                w_inv_s     = w_inv_s;
            end
        end
        if (w_hit_s) begin
            w_way_s = w_hit_way_s;
            w_adv_s = 1'b0;
        end else if (w_inv_s) begin
            w_way_s = w_inv_way_s;
            w_adv_s = 1'b0;
        end else begin
            w_way_s = ptr_r[w_idx_s];
            w_adv_s = 1'b1;
        end
        if (ptr_r[w_idx_s] == way_w_lp'(btb_ways_p - 1)) begin
            w_ptr_next_s = {way_w_lp{1'b0}};
        end else begin
            w_ptr_next_s = ptr_r[w_idx_s] + way_w_lp'(1);
        end
        w_mask_s          = {btb_ways_p{1'b0}};
        w_mask_s[w_way_s] = w_acc_s;
    end

`ifdef BP_FE_BTB_BYPASS_EN
    assign byp_s = r_acc_s & w_acc_s & (r_idx_s == w_idx_s) & (r_tag_s == w_tag_s);
`else
    assign byp_s = 1'b0;
`endif

    // Tag/valid/pointer update: INIT clears one set per cycle, READY installs writes.
    always_ff @(posedge clk_i) begin
        if (state_r == e_btb_init) begin
            for (int w = 0; w < btb_ways_p; w++) begin
                tag_r[init_cnt_r][w].v <= 1'b0;
            end
            ptr_r[init_cnt_r] <= {way_w_lp{1'b0}};
        end else if (w_acc_s) begin
            tag_r[w_idx_s][w_way_s].v   <= 1'b1;
            tag_r[w_idx_s][w_way_s].tag <= w_tag_s;
            if (w_adv_s) begin
                ptr_r[w_idx_s] <= w_ptr_next_s;
            end
        end
    end

    // Response pipeline stage: an accepted read is answered exactly one cycle later.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_r       <= 1'b0;
            resp_hit_r     <= 1'b0;
            resp_byp_r     <= 1'b0;
            resp_way_r     <= {way_w_lp{1'b0}};
            resp_byp_tgt_r <= {vaddr_width_p{1'b0}};
        end else begin
            resp_v_r       <= r_acc_s;
            resp_hit_r     <= r_acc_s & (r_hit_s | byp_s);
            resp_byp_r     <= byp_s;
            resp_way_r     <= r_way_s;
            resp_byp_tgt_r <= byp_s ? w_target_i : {vaddr_width_p{1'b0}};
        end
    end

    bsg_mem_1r1w_sync #(
        .width_p      (btb_ways_p * vaddr_width_p),
        .els_p        (sets_lp),
        .addr_width_p (btb_idx_width_p),
        .ways_p       (btb_ways_p)
    ) target_mem (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .w_v_i    (w_acc_s),
        .w_mask_i (w_mask_s),
        .w_addr_i (w_idx_s),
        .w_data_i ({btb_ways_p{w_target_i}}),
        .r_v_i    (r_acc_s),
        .r_addr_i (r_idx_s),
        .r_data_o (mem_data_s)
    );

    assign r_v_o   = resp_v_r;
    assign r_hit_o = resp_hit_r;

    // Target select: the hit way's lane, the forwarded target, or zero on a miss.
    always_comb begin
        r_target_o = {vaddr_width_p{1'b0}};
        if (resp_hit_r) begin
            if (resp_byp_r) begin
                r_target_o = resp_byp_tgt_r;
            end else begin
                r_target_o = mem_data_s[int'(resp_way_r)*vaddr_width_p +: vaddr_width_p];
            end
        end else begin
            r_target_o = {vaddr_width_p{1'b0}};
        end
    end

endmodule

// File: tb/tb_bp_fe_btb_tagged.sv
// Self-checking bench for bp_fe_btb_tagged using a reference model and an expectation queue.
// The bench honours BP_FE_BTB_BYPASS_EN the same way the design does.
module tb_bp_fe_btb_tagged;

    localparam int VW   = 39;
    localparam int IW   = 6;
    localparam int TW   = 10;
    localparam int NW   = 2;
    localparam int SETS = 64;

    logic          clk_i = 1'b0;
    logic          reset_i, flush_i, ready_o;
    logic          r_v_i, r_v_o, r_hit_o, w_v_i;
    logic [VW-1:0] r_addr_i, r_target_o, w_addr_i, w_target_i;

    always #5 clk_i = ~clk_i;

    bp_fe_btb_tagged #(
        .vaddr_width_p   (VW),
        .btb_idx_width_p (IW),
        .btb_tag_width_p (TW),
        .btb_ways_p      (NW)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .r_v_i      (r_v_i),
        .r_addr_i   (r_addr_i),
        .r_v_o      (r_v_o),
        .r_hit_o    (r_hit_o),
        .r_target_o (r_target_o),
        .w_v_i      (w_v_i),
        .w_addr_i   (w_addr_i),
        .w_target_i (w_target_i)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          v;
        logic          hit;
        logic [VW-1:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the BTB contents
    logic          mv   [SETS][NW];
    logic [TW-1:0] mtag [SETS][NW];
    logic [VW-1:0] mtgt [SETS][NW];
    int            mptr [SETS];
    bit            mready;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [VW-1:0] a);
        return int'(a[IW+1:2]);
    endfunction

    function automatic logic [TW-1:0] tag_of(input logic [VW-1:0] a);
        return a[TW+IW+1:IW+2];
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
            mptr[s] = 0;
        end
    endtask

    task automatic model_lookup(input logic [VW-1:0] a, output logic hit, output logic [VW-1:0] tgt);
        hit = 1'b0;
        tgt = '0;
        for (int w = 0; w < NW; w++) begin
            if (mv[idx_of(a)][w] && mtag[idx_of(a)][w] == tag_of(a)) begin
                hit = 1'b1;
                tgt = mtgt[idx_of(a)][w];
            end
        end
    endtask

    task automatic model_write(input logic [VW-1:0] a, input logic [VW-1:0] t);
        int s;
        int way;
        s   = idx_of(a);
        way = -1;
        for (int w = 0; w < NW; w++)
            if (mv[s][w] && mtag[s][w] == tag_of(a)) way = w;
        if (way < 0) begin
            for (int w = NW - 1; w >= 0; w--)
                if (!mv[s][w]) way = w;
            if (way < 0) begin
                way     = mptr[s];
                mptr[s] = (mptr[s] + 1) % NW;
            end
        end
        mv[s][way]   = 1'b1;
        mtag[s][way] = tag_of(a);
        mtgt[s][way] = t;
    endtask

    // One clock of stimulus: compute the expectation, update the model, then check one edge later
    task automatic step();
        exp_t e;
        e = '0;
        if (r_v_i && mready) begin
            e.v = 1'b1;
            model_lookup(r_addr_i, e.hit, e.tgt);
`ifdef BP_FE_BTB_BYPASS_EN
            if (w_v_i && !flush_i && idx_of(r_addr_i) == idx_of(w_addr_i)
                && tag_of(r_addr_i) == tag_of(w_addr_i)) begin
                e.hit = 1'b1;
                e.tgt = w_target_i;
            end
`endif
        end
        if (w_v_i && mready && !flush_i) model_write(w_addr_i, w_target_i);
        if (flush_i && mready) begin
            model_clear();
            mready = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check_eq("r_v_o", 64'(r_v_o), 64'(e.v));
        check_eq("r_hit_o", 64'(r_hit_o), 64'(e.hit));
        check_eq("r_target_o", 64'(r_target_o), 64'(e.tgt));
        r_v_i   = 1'b0;
        w_v_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            n++;
            r_v_i      = 1'b1;
            r_addr_i   = 39'h1000;
            w_v_i      = 1'b1;
            w_addr_i   = 39'h1000;
            w_target_i = 39'h7777;
            step();
        end
        check_eq("init_len", 64'(n), 64'd64);
        mready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        mready  = 1'b0;
        model_clear();
        for (int i = 0; i < n; i++) begin
            step();
            check_eq("ready_in_reset", 64'(ready_o), 64'd0);
        end
        reset_i = 1'b0;
    endtask

    task automatic do_write(input logic [VW-1:0] a, input logic [VW-1:0] t);
        w_v_i      = 1'b1;
        w_addr_i   = a;
        w_target_i = t;
        step();
    endtask

    task automatic do_read(input logic [VW-1:0] a);
        r_v_i    = 1'b1;
        r_addr_i = a;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i    = 1'b1;
        flush_i    = 1'b0;
        r_v_i      = 1'b0;
        w_v_i      = 1'b0;
        r_addr_i   = '0;
        w_addr_i   = '0;
        w_target_i = '0;
        mready     = 1'b0;
        model_clear();

        // Reset, then the init sweep with reads and writes that must be dropped
        do_reset(3);
        wait_ready();
        check_eq("ready_up", 64'(ready_o), 64'd1);

        // Install and look up
        do_read(39'h1000);
        do_write(39'h1000, 39'h2000);
        do_read(39'h1000);

        // Overwriting a hit way leaves the other way and the pointer alone
        do_write(39'h1000, 39'h3000);
        do_write(39'h5000, 39'h4400);
        do_read(39'h1000);
        do_read(39'h5000);

        // Third, fourth and fifth tag in set 0 rotate the victim pointer
        do_write(39'h9000, 39'h9900);
        do_read(39'h1000);
        do_read(39'h5000);
        do_read(39'h9000);
        do_write(39'hD000, 39'hDD00);
        do_read(39'h5000);
        do_read(39'h9000);
        do_read(39'hD000);
        do_write(39'h11000, 39'h11100);
        do_read(39'h9000);
        do_read(39'hD000);
        do_read(39'h11000);

        // A write and a read of a different set in the same cycle
        w_v_i = 1'b1; w_addr_i = 39'h1004; w_target_i = 39'h1234;
        r_v_i = 1'b1; r_addr_i = 39'h2008;
        step();
        do_read(39'h1004);

        // A write and a read of the same new entry in the same cycle
        w_v_i = 1'b1; w_addr_i = 39'h1400; w_target_i = 39'h5000;
        r_v_i = 1'b1; r_addr_i = 39'h1400;
        step();
        do_read(39'h1400);

        // A flush drops the same-cycle write; the same-cycle read sees pre-flush contents
        flush_i = 1'b1;
        w_v_i = 1'b1; w_addr_i = 39'h2000; w_target_i = 39'h2222;
        r_v_i = 1'b1; r_addr_i = 39'h1400;
        step();
        check_eq("ready_after_flush", 64'(ready_o), 64'd0);
        wait_ready();
        do_read(39'h1400);
        do_read(39'h1004);
        do_read(39'h2000);
        do_read(39'h11000);

        // Reset part-way through a sweep restarts it from set 0
        do_write(39'h3000, 39'h3333);
        flush_i = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        do_reset(2);
        wait_ready();
        do_read(39'h3000);

        // Reset during operation clears everything
        do_write(39'h3000, 39'h3333);
        do_read(39'h3000);
        do_reset(1);
        wait_ready();
        do_read(39'h3000);

        // Random traffic over a few sets and tags
        for (int i = 0; i < 400; i++) begin
            r_v_i      = 1'($urandom_range(0, 1));
            w_v_i      = 1'($urandom_range(0, 1));
            r_addr_i   = {21'd0, 10'($urandom_range(1, 5)), 6'($urandom_range(0, 3)), 2'b00};
            w_addr_i   = {21'd0, 10'($urandom_range(1, 5)), 6'($urandom_range(0, 3)), 2'b00};
            w_target_i = 39'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
